// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the skid pipeline stage.
// The entry record carries the data field beside this header because its width is a module parameter.
package pipe_stage_skid_pkg;
   localparam int RD_W       = 5;
   localparam int DATA_W_DEF = 101;
   localparam logic [DATA_W_DEF-1:0] NOP_VAL_DEF = '0;

   typedef struct packed {
      logic            valid;
      logic [RD_W-1:0] rd;
      logic            regwrite;
   } entry_meta_t;
endpackage

// File: rtl/pipe_entry_reg.sv
// One held beat: valid/rd/regwrite header plus payload, with load and clear enables.
module pipe_entry_reg
   import pipe_stage_skid_pkg::*;
#(
   parameter int                DATA_W  = DATA_W_DEF,
   parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clr,
   input  logic [DATA_W-1:0] d_data,
   input  logic [RD_W-1:0]   d_rd,
   input  logic              d_regwrite,
   output entry_meta_t       q_meta,
   output logic [DATA_W-1:0] q_data
);
   entry_meta_t       meta_d, meta_q;
   logic [DATA_W-1:0] data_d, data_q;

   // Clear wins over load so a flush always empties the entry.
   always_comb begin
      meta_d = meta_q;
      data_d = data_q;
      if (clr) begin
         meta_d = '0;
         data_d = NOP_VAL;
      end else if (load) begin
         meta_d.valid    = 1'b1;
         meta_d.rd       = d_rd;
         meta_d.regwrite = d_regwrite;
         data_d          = d_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         data_q <= NOP_VAL;
      end else begin
         meta_q <= meta_d;
         data_q <= data_d;
      end
   end

   assign q_meta = meta_q;
   assign q_data = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with optional two-entry skid buffer (SKID=1) or plain register (SKID=0).
// MAIN is always the head; SKB catches the beat that arrives while the head is stalled.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int                DATA_W  = DATA_W_DEF,
   parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_VAL_DEF),
   parameter int                SKID    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_regwrite,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_regwrite,
   output logic [1:0]        level
);
   entry_meta_t       main_m, skb_m;
   logic [DATA_W-1:0] main_data, skb_data;
   logic              accept, drain;
   logic              main_load, main_clr, main_from_skb;
   logic              skb_load, skb_clr;
   logic              main_v_n, skb_v_n;
   logic [DATA_W-1:0] main_in_data;
   logic [RD_W-1:0]   main_in_rd;
   logic              main_in_rw;
   logic [1:0]        level_d, level_q;

   assign drain  = main_m.valid && out_ready;
   assign accept = in_valid && in_ready && !flush;

   generate
      if (SKID != 0) begin : g_ready_skid
         // Straight from the SKB valid flop: no path from out_ready.
         assign in_ready = !skb_m.valid;
      end else begin : g_ready_reg
         assign in_ready = !main_m.valid || out_ready;
      end
   endgenerate

   always_comb begin
      main_load     = 1'b0;
      main_from_skb = 1'b0;
      skb_load      = 1'b0;
      if (SKID != 0) begin
         if (skb_m.valid) begin
            if (drain) begin
               main_load     = 1'b1;
               main_from_skb = 1'b1;
            end
         end else if (accept) begin
            if (!main_m.valid || drain) main_load = 1'b1;
            else                        skb_load  = 1'b1;
         end
      end else begin
         main_load = accept;
      end
      main_clr = flush || (drain && !main_load);
      skb_clr  = flush || (skb_m.valid && drain);

      main_v_n = main_clr ? 1'b0 : (main_load ? 1'b1 : main_m.valid);
      skb_v_n  = skb_clr  ? 1'b0 : (skb_load  ? 1'b1 : skb_m.valid);
      level_d  = {1'b0, main_v_n} + {1'b0, skb_v_n};

      main_in_data = main_from_skb ? skb_data        : in_data;
      main_in_rd   = main_from_skb ? skb_m.rd        : in_rd;
      main_in_rw   = main_from_skb ? skb_m.regwrite  : in_regwrite;
   end

   pipe_entry_reg #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_main (
      .clk(clk), .reset(reset), .load(main_load), .clr(main_clr),
      .d_data(main_in_data), .d_rd(main_in_rd), .d_regwrite(main_in_rw),
      .q_meta(main_m), .q_data(main_data)
   );

   generate
      if (SKID != 0) begin : g_skb
         pipe_entry_reg #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_skb (
            .clk(clk), .reset(reset), .load(skb_load), .clr(skb_clr),
            .d_data(in_data), .d_rd(in_rd), .d_regwrite(in_regwrite),
            .q_meta(skb_m), .q_data(skb_data)
         );
      end else begin : g_no_skb
         assign skb_m    = '0;
         assign skb_data = NOP_VAL;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) level_q <= 2'd0;
      else       level_q <= level_d;
   end

   assign level        = level_q;
   assign out_valid    = main_m.valid;
   assign out_data     = main_m.valid ? main_data : NOP_VAL;
   assign out_rd       = main_m.valid ? main_m.rd : '0;
   assign out_regwrite = main_m.valid && main_m.regwrite;
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 101, width of the pipeline payload.
REQ-002 SHALL have parameter NOP_VAL, default all-zero DATA_W-bit value, payload driven when no beat is held (bubble).
REQ-003 SHALL have parameter SKID, default 1: 1 = two-entry skid mode, 0 = single-register mode.
REQ-004 SHALL have ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous kill of all held beats
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage accepts beat this cycle
- in_data  input  DATA_W  upstream payload
- in_rd  input  5  destination register index
- in_regwrite  input  1  beat writes register file
- out_valid  output  1  beat presented downstream
- out_ready  input  1  downstream accepts beat
- out_data  output  DATA_W  payload of head beat
- out_rd  output  5  head destination index
- out_regwrite  output  1  head regwrite, gated by out_valid
- level  output  2  held beats (0..2)

Function
REQ-005 SHALL accept a beat when in_valid && in_ready; SHALL present a beat when out_valid; a beat leaves when out_valid && out_ready.
REQ-006 SHALL hold entries MAIN (head) and, in SKID=1 mode, SKB; each entry = {valid, data, rd, regwrite}.
REQ-007 Occupancy states: EMPTY (no valid), ONE (MAIN valid), TWO (MAIN and SKB valid); TWO unreachable when SKID=0.
REQ-008 SKID=1: in_ready SHALL be registered, equal to !SKB.valid; no combinational path from out_ready to in_ready.
REQ-009 SKID=0: in_ready SHALL be !MAIN.valid || out_ready (combinational).
REQ-010 Transitions, no flush: EMPTY+accept -> ONE (MAIN <= in); ONE+accept+drain -> ONE (MAIN <= in); ONE+accept+!drain -> TWO (SKB <= in, SKID=1 only); ONE+drain+!accept -> EMPTY; TWO+drain -> ONE (MAIN <= SKB); TWO never accepts.
REQ-011 Latency: accepted beat SHALL appear on out_* the cycle after acceptance when the stage was EMPTY or draining; beat order SHALL be preserved; no beat duplicated or lost.
REQ-012 When !out_valid, out_data SHALL equal NOP_VAL, out_rd SHALL be 0, out_regwrite SHALL be 0.
REQ-013 out_regwrite SHALL be MAIN.regwrite && MAIN.valid; out_rd/out_data SHALL reflect MAIN while valid.
REQ-014 flush SHALL clear all valid bits at the next clock edge; a beat offered in the flush cycle SHALL be dropped even if in_ready=1; a downstream handshake in the flush cycle still completes (beat counts as delivered).
REQ-015 flush has priority over accept and drain; after flush, in_ready SHALL be 1 in the following cycle.
REQ-016 level SHALL equal MAIN.valid + SKB.valid, registered.
REQ-017 Outputs SHALL not change while out_valid && !out_ready and flush=0 (stall holds head stable).

Reset
REQ-018 Reset SHALL asynchronously clear MAIN.valid and SKB.valid, and set data fields to NOP_VAL, rd to 0, regwrite to 0.
REQ-019 During and after reset: out_valid=0, out_data=NOP_VAL, out_rd=0, out_regwrite=0, level=0, in_ready=1.
REQ-020 Reset asserted mid-transfer SHALL discard all held beats; first post-reset edge SHALL accept normally.

Structure
REQ-021 Shared package SHALL hold the entry record type (valid, rd, regwrite, data), the 5-bit register-index width constant and the NOP_VAL default.
REQ-022 One sub-module SHALL be natural: pipe_entry_reg, a single resettable entry with load and clear enables, instantiated for MAIN and SKB.

Verification
REQ-023 Stream: SKID=1, out_ready=1, in_data=1,2,3 back-to-back -> out_data 1,2,3 one cycle later each, level=1 steady, in_ready=1 throughout.
REQ-024 Stall: beats A=0x10, B=0x20 while out_ready=0 -> level=2, in_ready=0, out_data=0x10 held; release -> 0x10 then 0x20, level 2->1->0.
REQ-025 Flush: level=2, flush=1 with in_valid=1 in_data=0x30 -> next cycle level=0, out_valid=0, out_data=NOP_VAL, 0x30 never appears.
REQ-026 Bubble gating: in_regwrite=1 in_rd=7 beat drained, no new beat -> out_regwrite=0, out_rd=0 next cycle.
REQ-027 Reset mid-stall: level=2, reset pulsed between edges -> immediate out_valid=0, level=0, in_ready=1; next beat 0x40 delivered one cycle after acceptance.
REQ-028 SKID=0: out_ready=0 with MAIN valid -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, accept-and-drain keeps level=1.
